// File: rtl/inst_fetcher.sv
// inst_fetcher: PC owner that probes the Icache, requests misses from memory and delivers {pc, inst}
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        iq_full,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);
  typedef enum logic [1:0] {FETCH, MISS, DROP} state_t;
  state_t state;
  logic [31:0] pc, miss_addr;
  logic unused_data;
  assign unused_data = ^mc_data;
  assign ic_addr = state == FETCH ? pc : miss_addr;
  // MISS and DROP differ only in whether the refill is still wanted; both wait for mc_done
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      state <= FETCH;
      mc_req <= 1'b0;
      mc_addr <= 32'h0;
      miss_addr <= 32'h0;
      if_valid <= 1'b0;
      if_inst <= 32'h0;
      if_pc <= 32'h0;
    end else if (rdy) begin
      if_valid <= 1'b0;
      if (state == FETCH) begin
        if (flush) pc <= flush_pc;
        else if (ic_hit && !iq_full) begin
          if_valid <= 1'b1;
          if_inst <= ic_inst;
          if_pc <= pc;
          pc <= pc + 32'd4;
        end else if (!ic_hit) begin
          miss_addr <= pc;
          mc_addr <= pc;
          mc_req <= 1'b1;
          state <= MISS;
        end
      end else begin
        if (flush) pc <= flush_pc;
        if (mc_done) begin
          mc_req <= 1'b0;
          state <= FETCH;
        end else if (flush) state <= DROP;
      end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed and random stimulus checked against a request-level fetch model
module tb_inst_fetcher;
  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b0, ic_hit = 1'b0, mc_done = 1'b0, iq_full = 1'b0, flush = 1'b0;
  logic [31:0] ic_inst = 32'h0, mc_data = 32'h0, flush_pc = 32'h0;
  logic [31:0] ic_addr, mc_addr, if_inst, if_pc;
  logic mc_req, if_valid;
  int checks = 0, errors = 0;
  bit started = 0;
  logic [31:0] m_pc, m_miss, m_maddr, m_inst, m_ipc;
  bit m_pend, m_valid;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_inst(ic_inst),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
    .iq_full(iq_full), .flush(flush), .flush_pc(flush_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit en, input bit h, input bit f, input bit fl,
                      input logic [31:0] fp, input bit d);
    rst = r; rdy = en; ic_hit = h; iq_full = f; flush = fl; flush_pc = fp; mc_done = d;
    mc_data = $urandom; ic_inst = $urandom;
    #1;
    if (started) chk("ic_addr", ic_addr, m_pend ? m_miss : m_pc);
    if (r) begin
      m_pc = 0; m_pend = 0; m_miss = 0; m_maddr = 0; m_valid = 0; m_inst = 0; m_ipc = 0;
    end else if (en) begin
      m_valid = 0;
      if (!m_pend) begin
        if (fl) m_pc = fp;
        else if (h) begin
          if (!f) begin
            m_valid = 1; m_inst = ic_inst; m_ipc = m_pc; m_pc = m_pc + 32'd4;
          end
        end else begin
          m_pend = 1; m_miss = m_pc; m_maddr = m_pc;
        end
      end else begin
        if (fl) m_pc = fp;
        if (d) m_pend = 0;
      end
    end
    @(negedge clk);
    started = 1;
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_pc", if_pc, m_ipc);
    chk("if_inst", if_inst, m_inst);
    chk("mc_req", {31'b0, mc_req}, {31'b0, m_pend});
    chk("mc_addr", mc_addr, m_maddr);
    chk("ic_addr_post", ic_addr, m_pend ? m_miss : m_pc);
  endtask

  initial begin
    logic [31:0] last;
    @(negedge clk);
    tick(1, 1, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_req", {31'b0, mc_req}, 32'h0);
    chk("rst_ic_addr", ic_addr, 32'h0);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t1_pc0", if_pc, 32'h0);
    tick(0, 1, 1, 0, 0, 0, 0);
    last = ic_inst;
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t1_pc8", if_pc, 32'h8);
    chk("t1_inst", if_inst, ic_inst);
    tick(0, 1, 1, 0, 1, 32'h40, 0);
    chk("t4_no_valid", {31'b0, if_valid}, 32'h0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("t2_req", {31'b0, mc_req}, 32'h1);
    chk("t2_mc_addr", mc_addr, 32'h40);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t2_ic_addr", ic_addr, 32'h40);
    tick(0, 1, 0, 0, 0, 0, 1);
    chk("t2_req_drop", {31'b0, mc_req}, 32'h0);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t2_deliver", if_pc, 32'h40);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 1, 32'h1000, 0);
    chk("t3_req_held", {31'b0, mc_req}, 32'h1);
    chk("t3_ic_addr", ic_addr, 32'h44);
    tick(0, 1, 1, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 1);
    chk("t3_req_off", {31'b0, mc_req}, 32'h0);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t3_first", if_pc, 32'h1000);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 1, 0, 0, 0);
      chk("t5_stall", {31'b0, if_valid}, 32'h0);
    end
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t5_resume", if_pc, 32'h1004);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("rdy_hold_valid", {31'b0, if_valid}, 32'h1);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t5_next", if_pc, 32'h1008);
    tick(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("t6_req_frozen", {31'b0, mc_req}, 32'h1);
    chk("t6_addr_frozen", ic_addr, 32'hFFFF_FFFC);
    tick(0, 1, 0, 0, 0, 0, 1);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t6_top", if_pc, 32'hFFFF_FFFC);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("t6_wrap", if_pc, 32'h0);
    if (last == 32'h0) last = 32'h1;
    for (int i = 0; i < 3000; i++)
      tick($urandom % 300 == 0, $urandom % 10 != 0, $urandom % 4 != 0, $urandom % 4 == 0,
           $urandom % 12 == 0, ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
           m_pend && ($urandom % 3 == 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
